single_exp2_pipe: RTL

//  Pipelined IEEE-754 single-precision 2^x unit with valid/ready back-pressure.

---
 rtl/single_exp2_pipe_if.sv | 37 +++
 rtl/single_exp2_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/single_exp2_pipe_if.sv
// Handshake bundle for single_exp2_pipe: operand in, 2^x result out.
// The flags signal exists only when SINGLE_EXP2_FLAGS_EN is defined.
interface single_exp2_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;
`ifdef SINGLE_EXP2_FLAGS_EN
  logic [2:0]  flags;
`endif

  modport master (
    output in_valid,
    output a,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  c
`ifdef SINGLE_EXP2_FLAGS_EN
    , input flags
`endif
  );

  modport slave (
    input  in_valid,
    input  a,
    input  out_ready,
    output in_ready,
    output out_valid,
    output c
`ifdef SINGLE_EXP2_FLAGS_EN
    , output flags
`endif
  );
endinterface

// File: rtl/single_exp2_pipe.sv
// 4-stage float32 2^x: Q9.FRAC_W split, LUT + linear interpolation.
// Define SINGLE_EXP2_FLAGS_EN for the {invalid, overflow, underflow} port.
module single_exp2_pipe #(
  parameter int FRAC_W   = 23,
  parameter int LUT_BITS = 6
) (
  input  logic           clk,
  input  logic           rst,
  single_exp2_pipe_if.slave io
);

  localparam int W  = 9 + FRAC_W;
  localparam int R  = FRAC_W - LUT_BITS;
  localparam int N  = 1 << LUT_BITS;
  localparam int PW = 25 + R;
  localparam logic [LUT_BITS:0] ONE = 1;

  function automatic logic [127:0] isqrt(input logic [127:0] v);
    logic [127:0] n, r, b;
    n = v;
    r = '0;
    for (int i = 63; i >= 0; i--) begin
      b = 128'd1 << (2 * i);
      if (n >= r + b) begin
        n = n - r - b;
        r = (r >> 1) + b;
      end else begin
        r = r >> 1;
      end
    end
    return r;
  endfunction

  // 2^(k/N) in Q1.23, built from repeated square roots of 2 in Q2.60
  function automatic logic [24:0] lut_entry(input int k);
    logic [127:0] c, p;
    if (k >= N) return 25'd1 << 24;
    c = 128'd2 << 60;
    p = 128'd1 << 60;
    for (int i = 1; i <= LUT_BITS; i++) begin
      c = isqrt(c << 60);
      if (((k >> (LUT_BITS - i)) & 1) != 0)
        p = (p * c) >> 60;
    end
    return 25'((p + (128'd1 << 36)) >> 37);
  endfunction

  logic [24:0] lut [0:N];
  for (genvar g = 0; g <= N; g++) begin : g_lut
    localparam logic [24:0] V = lut_entry(g);
    assign lut[g] = V;
  end

  logic        en;
  logic        v1_q, v2_q, v3_q, ov_q;
  logic        s1_spec_q, s1_spec_d;
  logic [31:0] s1_res_q, s1_res_d;
  logic [W-1:0] s1_x_q, s1_x_d;
  logic        s2_spec_q, s2_spec_d;
  logic [31:0] s2_res_q, s2_res_d;
  logic [7:0]  s2_ex_q, s2_ex_d;
  logic [24:0] s2_t0_q, s2_t0_d;
  logic [24:0] s2_t1_q, s2_t1_d;
  logic [R-1:0] s2_r_q, s2_r_d;
  logic        s3_spec_q;
  logic [31:0] s3_res_q;
  logic [7:0]  s3_ex_q;
  logic [22:0] s3_m_q, s3_m_d;
  logic [31:0] c_q, c_d;

  assign en          = !(ov_q && !io.out_ready);
  assign io.in_ready = en;
  assign io.out_valid = ov_q;
  assign io.c        = c_q;

  logic        sgn_w;
  logic [7:0]  e_w;
  logic [22:0] man_w;
  logic [23:0] sig_w;
  logic        nan_w, inf_w, zde_w, tiny_w, big_w;
  int          sh;
  logic [W-1:0] mag;
  logic        lost;

  assign sgn_w  = io.a[31];
  assign e_w    = io.a[30:23];
  assign man_w  = io.a[22:0];
  assign sig_w  = {1'b1, man_w};
  assign nan_w  = (e_w == 8'hFF) && (man_w != '0);
  assign inf_w  = (e_w == 8'hFF) && (man_w == '0);
  assign zde_w  = (e_w == 8'h00);
  assign tiny_w = !zde_w && (int'(e_w) < 127 - FRAC_W);
  assign big_w  = (e_w >= 8'd135) && (e_w != 8'hFF);

  // S1: classify and convert to fixed point, rounding toward -inf
  always_comb begin
    s1_spec_d = 1'b1;
    s1_res_d  = 32'h3F80_0000;
    s1_x_d    = '0;
    mag       = '0;
    lost      = 1'b0;
    sh        = int'(e_w) - 150 + FRAC_W;
    unique case (1'b1)
      nan_w:          s1_res_d = 32'h7FC0_0000;
      inf_w, big_w:   s1_res_d = sgn_w ? 32'h0 : 32'h7F80_0000;
      zde_w, tiny_w:  s1_res_d = 32'h3F80_0000;
      default: begin
        s1_spec_d = 1'b0;
        if (sh >= 0) begin
          mag = W'(sig_w) << sh;
        end else begin
          mag  = W'(sig_w >> (-sh));
          lost = |(sig_w & ~(24'hFF_FFFF << (-sh)));
        end
        s1_x_d = sgn_w ? -(mag + W'(lost)) : mag;
      end
    endcase
  end

  logic signed [8:0] n_w;
  logic [LUT_BITS-1:0] k_w;
  logic [LUT_BITS:0] k0_w, k1_w;
  logic ovf_w, unf_w;

  assign n_w   = s1_x_q[W-1:FRAC_W];
  assign k_w   = s1_x_q[FRAC_W-1 -: LUT_BITS];
  assign k0_w  = {1'b0, k_w};
  assign k1_w  = k0_w + ONE;
  assign ovf_w = !s1_spec_q && (n_w > 9'sd127);
  assign unf_w = !s1_spec_q && (n_w < -9'sd126);

  // S2: integer/fraction split and table read
  always_comb begin
    s2_spec_d = s1_spec_q | ovf_w | unf_w;
    s2_res_d  = ovf_w ? 32'h7F80_0000 : (unf_w ? 32'h0 : s1_res_q);
    s2_ex_d   = 8'(n_w + 9'sd127);
    s2_t0_d   = lut[k0_w];
    s2_t1_d   = lut[k1_w];
    s2_r_d    = s1_x_q[R-1:0];
  end

  logic [24:0]   diff_w;
  logic [PW-1:0] prod_w;

  // S3: interpolate; result stays below 2.0 so the hidden bit is dropped
  always_comb begin
    diff_w = s2_t1_q - s2_t0_q;
    prod_w = PW'(diff_w) * PW'(s2_r_q);
    s3_m_d = 23'(s2_t0_q + 25'(prod_w >> R));
  end

  assign c_d = s3_spec_q ? s3_res_q : {1'b0, s3_ex_q, s3_m_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      ov_q      <= 1'b0;
      s1_spec_q <= 1'b0;
      s1_res_q  <= '0;
      s1_x_q    <= '0;
      s2_spec_q <= 1'b0;
      s2_res_q  <= '0;
      s2_ex_q   <= '0;
      s2_t0_q   <= '0;
      s2_t1_q   <= '0;
      s2_r_q    <= '0;
      s3_spec_q <= 1'b0;
      s3_res_q  <= '0;
      s3_ex_q   <= '0;
      s3_m_q    <= '0;
      c_q       <= '0;
    end else if (en) begin
      v1_q      <= io.in_valid;
      v2_q      <= v1_q;
      v3_q      <= v2_q;
      ov_q      <= v3_q;
      s1_spec_q <= s1_spec_d;
      s1_res_q  <= s1_res_d;
      s1_x_q    <= s1_x_d;
      s2_spec_q <= s2_spec_d;
      s2_res_q  <= s2_res_d;
      s2_ex_q   <= s2_ex_d;
      s2_t0_q   <= s2_t0_d;
      s2_t1_q   <= s2_t1_d;
      s2_r_q    <= s2_r_d;
      s3_spec_q <= s2_spec_q;
      s3_res_q  <= s2_res_q;
      s3_ex_q   <= s2_ex_q;
      s3_m_q    <= s3_m_d;
      c_q       <= c_d;
    end
  end

`ifdef SINGLE_EXP2_FLAGS_EN
  logic [2:0] s1_flg_q, s2_flg_q, s3_flg_q, flg_q;

  assign io.flags = flg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_flg_q <= '0;
      s2_flg_q <= '0;
      s3_flg_q <= '0;
      flg_q    <= '0;
    end else if (en) begin
      s1_flg_q <= {nan_w, big_w & ~sgn_w, big_w & sgn_w};
      s2_flg_q <= s1_flg_q | {1'b0, ovf_w, unf_w};
      s3_flg_q <= s2_flg_q;
      flg_q    <= s3_flg_q;
    end
  end
`endif

endmodule
